bcd_to_bin_serial: RTL and testbench

- Serial BCD-to-binary converter. It performs reverse double-dabble: each iteration shifts right by one, then subtracts 3 from every BCD digit that is ≥ 8.
- It is the inverse of the existing binary-to-BCD shift/add-3 path, and sits behind numeric-entry logic (keypad or UART decimal input) to turn packed BCD back into binary for arithmetic.
- Operation is multi-cycle with a start/busy/done handshake and one iteration per clock.

---
 rtl/bcd_pkg.sv | 36 +++
 rtl/bcd_to_bin_serial_if.sv | 32 +++
 rtl/bcd_rshift_correct.sv | 35 +++
 rtl/bcd_to_bin_serial.sv | 140 ++++++++++++++
 tb/tb_bcd_to_bin_serial.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD-to-binary converter.
// Provides digit-arithmetic constants, the controller state type and
// small constant functions used to size counters and check parameters.
package bcd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int BCD_CORR   = 3;
  localparam int BCD_THRESH = 8;
  localparam int BCD_MAX    = 9;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) begin
      r = r + 1;
    end
    return r;
  endfunction

  // 10^n as a 64-bit value, used to check the binary width is large enough.
  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_to_bin_serial_if.sv
// Handshake/data bundle of the serial BCD-to-binary converter.
//   start   : request a conversion (master -> slave)
//   bcd_in  : packed BCD operand, digit 0 in bits [3:0] (master -> slave)
//   busy    : conversion in progress (slave -> master)
//   done    : one-cycle completion pulse (slave -> master)
//   bin_out : binary result, held until next done (slave -> master)
//   err     : last operand had a digit > 9 (slave -> master)
interface bcd_to_bin_serial_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);

  logic                      start;
  logic [DIGIT_W*DIGITS-1:0] bcd_in;
  logic                      busy;
  logic                      done;
  logic [BIN_W-1:0]          bin_out;
  logic                      err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );

endinterface

// File: rtl/bcd_rshift_correct.sv
// One reverse double-dabble step: shift the work register right by one,
// then subtract 3 from every BCD digit field that reached 8 or more.
// Digit fields are corrected independently; no borrow crosses fields.
//   i_work : current work register {BCD field, binary accumulator}
//   o_work : work register after one iteration
module bcd_rshift_correct
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
)(
  input  logic [DIGIT_W*DIGITS+BIN_W-1:0] i_work,
  output logic [DIGIT_W*DIGITS+BIN_W-1:0] o_work
);

  localparam int WORK_W = DIGIT_W * DIGITS + BIN_W;

  logic [WORK_W-1:0] w_shift;

  assign w_shift = {1'b0, i_work[WORK_W-1:1]};

  // Per-digit correction of the shifted BCD field; binary bits pass through.
  always_comb begin
    o_work = w_shift;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_shift[BIN_W + d*DIGIT_W +: DIGIT_W] >= DIGIT_W'(BCD_THRESH)) begin
        o_work[BIN_W + d*DIGIT_W +: DIGIT_W] =
          w_shift[BIN_W + d*DIGIT_W +: DIGIT_W] - DIGIT_W'(BCD_CORR);
      end else begin
        o_work[BIN_W + d*DIGIT_W +: DIGIT_W] = w_shift[BIN_W + d*DIGIT_W +: DIGIT_W];
      end
    end
  end

endmodule

// File: rtl/bcd_to_bin_serial.sv
// Serial BCD-to-binary converter (reverse double-dabble, one iteration
// per clock). A start in IDLE loads the work register and runs exactly
// BIN_W iterations, then pulses done with bin_out/err updated.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of bcd_to_bin_serial_if (start, bcd_in, busy,
//         done, bin_out, err)
module bcd_to_bin_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
)(
  input logic                clk,
  input logic                rst,
  bcd_to_bin_serial_if.slave bus
);

  localparam int BCD_W  = DIGIT_W * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (clog2(BIN_W) < 1) ? 1 : clog2(BIN_W);

  // The binary field must be able to hold the largest decimal operand.
  generate
    if ((BIN_W >= 64) ? 1'b0 : ((64'd1 << BIN_W) < pow10(DIGITS))) begin : g_width_err
      $error("bcd_to_bin_serial: 2**BIN_W must be >= 10**DIGITS");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_next;
  logic [WORK_W-1:0]  r_work;
  logic [WORK_W-1:0]  w_work_next;
  logic [WORK_W-1:0]  w_work_step;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               r_inv;
  logic               w_inv_next;
  logic               w_inv_in;
  logic               r_busy;
  logic               w_busy_next;
  logic               r_done;
  logic               w_done_next;
  logic [BIN_W-1:0]   r_bin;
  logic [BIN_W-1:0]   w_bin_next;
  logic               r_err;
  logic               w_err_next;

  bcd_rshift_correct #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_step (
    .i_work (r_work),
    .o_work (w_work_step)
  );

  // Flag any incoming digit above 9; captured together with the operand.
  always_comb begin
    w_inv_in = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      w_inv_in = w_inv_in | (bus.bcd_in[d*DIGIT_W +: DIGIT_W] > DIGIT_W'(BCD_MAX));
    end
  end

  // Controller next-state and datapath/output next values.
  always_comb begin
    w_state_next = r_state;
    w_work_next  = r_work;
    w_cnt_next   = r_cnt;
    w_inv_next   = r_inv;
    w_done_next  = 1'b0;
    w_bin_next   = r_bin;
    w_err_next   = r_err;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = SHIFT;
          w_work_next  = {bus.bcd_in, {BIN_W{1'b0}}};
          w_inv_next   = w_inv_in;
          w_cnt_next   = {CNT_W{1'b0}};
        end else begin
          w_state_next = IDLE;
        end
      end
      SHIFT: begin
        w_work_next = w_work_step;
        w_cnt_next  = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(BIN_W - 1)) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
          w_err_next   = r_inv;
          // Invalid operands still take the full iteration count, then report 0.
          w_bin_next   = r_inv ? {BIN_W{1'b0}} : w_work_step[BIN_W-1:0];
        end else begin
          w_state_next = SHIFT;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    w_busy_next = (w_state_next == SHIFT);
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work <= {WORK_W{1'b0}};
      r_cnt  <= {CNT_W{1'b0}};
      r_inv  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_bin  <= {BIN_W{1'b0}};
      r_err  <= 1'b0;
    end else begin
      r_work <= w_work_next;
      r_cnt  <= w_cnt_next;
      r_inv  <= w_inv_next;
      r_busy <= w_busy_next;
      r_done <= w_done_next;
      r_bin  <= w_bin_next;
      r_err  <= w_err_next;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bin_out = r_bin;
  assign bus.err     = r_err;

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Scoreboard bench for bcd_to_bin_serial: drivers push expected results,
// monitors pop and compare on every done pulse. Two instances cover the
// default 3-digit/10-bit and a 4-digit/14-bit configuration.
module tb_bcd_to_bin_serial;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_fail;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    int          k;
  } exp_t;

  exp_t q3[$];
  exp_t q4[$];
  logic prev3;
  logic prev4;

  bcd_to_bin_serial_if #(.DIGITS(3), .BIN_W(10)) if3 ();
  bcd_to_bin_serial_if #(.DIGITS(4), .BIN_W(14)) if4 ();

  bcd_to_bin_serial #(.DIGITS(3), .BIN_W(10)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));
  bcd_to_bin_serial #(.DIGITS(4), .BIN_W(14)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor for the 3-digit instance.
  always @(negedge clk) begin
    exp_t e;
    if (if3.done === 1'b1) begin
      check("done3_not_twice", {31'b0, prev3}, 32'd0);
      check("busy3_low_at_done", {31'b0, if3.busy}, 32'd0);
      if (q3.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL done3_unexpected: got done=1, want no done");
      end else begin
        e = q3.pop_front();
        check("bin3", {22'b0, if3.bin_out}, {18'b0, e.bin});
        check("err3", {31'b0, if3.err}, {31'b0, e.err});
        check("lat3", cyc - e.k, 32'd10);
      end
    end
    prev3 <= if3.done;
  end

  // Monitor for the 4-digit instance.
  always @(negedge clk) begin
    exp_t e;
    if (if4.done === 1'b1) begin
      check("done4_not_twice", {31'b0, prev4}, 32'd0);
      if (q4.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL done4_unexpected: got done=1, want no done");
      end else begin
        e = q4.pop_front();
        check("bin4", {18'b0, if4.bin_out}, {18'b0, e.bin});
        check("err4", {31'b0, if4.err}, {31'b0, e.err});
        check("lat4", cyc - e.k, 32'd14);
      end
    end
    prev4 <= if4.done;
  end

  // Issue one conversion on the 3-digit instance and wait for its done.
  // Leaves the caller at the negedge of the done cycle.
  task automatic conv3(input logic [11:0] bcd, input logic [9:0] eb, input logic ee,
                       input int gap, input bit mid);
    bit got;
    repeat (gap) @(negedge clk);
    if3.start  = 1'b1;
    if3.bcd_in = bcd;
    q3.push_back('{bin: 14'(eb), err: ee, k: cyc + 1});
    @(negedge clk);
    if3.start  = 1'b0;
    if3.bcd_in = 12'($urandom);
    check("busy3_rise", {31'b0, if3.busy}, 32'd1);
    if (mid) begin
      @(negedge clk);
      @(negedge clk);
      if3.start  = 1'b1;
      if3.bcd_in = 12'h999;
      @(negedge clk);
      if3.start  = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (if3.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout3: got no done, want done for bcd %0h", bcd);
    end
  endtask

  // Issue one conversion on the 4-digit instance and wait for its done.
  task automatic conv4(input logic [15:0] bcd, input logic [13:0] eb);
    bit got;
    @(negedge clk);
    if4.start  = 1'b1;
    if4.bcd_in = bcd;
    q4.push_back('{bin: eb, err: 1'b0, k: cyc + 1});
    @(negedge clk);
    if4.start  = 1'b0;
    if4.bcd_in = 16'($urandom);
    check("busy4_rise", {31'b0, if4.busy}, 32'd1);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (if4.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout4: got no done, want done for bcd %0h", bcd);
    end
  endtask

  initial begin
    cyc        = 0;
    n_cmp      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    if3.start  = 1'b0;
    if3.bcd_in = 12'h000;
    if4.start  = 1'b0;
    if4.bcd_in = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'b0, if3.busy}, 32'd0);
    check("rst_done", {31'b0, if3.done}, 32'd0);
    check("rst_bin", {22'b0, if3.bin_out}, 32'd0);
    check("rst_err", {31'b0, if3.err}, 32'd0);
    check("rst_busy4", {31'b0, if4.busy}, 32'd0);
    check("rst_bin4", {18'b0, if4.bin_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversions, including boundaries and an invalid digit.
    conv3(12'h999, 10'h3E7, 1'b0, 1, 1'b0);
    conv3(12'h000, 10'h000, 1'b0, 1, 1'b0);
    conv3(12'h255, 10'h0FF, 1'b0, 1, 1'b0);
    conv3(12'h100, 10'h064, 1'b0, 2, 1'b0);
    conv3(12'h1A3, 10'h000, 1'b1, 1, 1'b0);
    conv3(12'h042, 10'h02A, 1'b0, 1, 1'b0);

    // Start while busy is ignored; then a start held in the done cycle is accepted.
    conv3(12'h123, 10'h07B, 1'b0, 1, 1'b1);
    conv3(12'h500, 10'h1F4, 1'b0, 0, 1'b0);
    @(negedge clk);
    check("hold_bin", {22'b0, if3.bin_out}, 32'h1F4);
    check("idle_busy", {31'b0, if3.busy}, 32'd0);

    // Reset during the 5th SHIFT cycle aborts with no done.
    if3.start  = 1'b1;
    if3.bcd_in = 12'h999;
    @(negedge clk);
    if3.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", {31'b0, if3.busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'b0, if3.busy}, 32'd0);
    check("abort_done", {31'b0, if3.done}, 32'd0);
    check("abort_bin", {22'b0, if3.bin_out}, 32'd0);
    check("abort_err", {31'b0, if3.err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_still_idle", {31'b0, if3.busy}, 32'd0);
    conv3(12'h007, 10'h007, 1'b0, 1, 1'b0);

    // Wider configuration.
    conv4(16'h9999, 14'h270F);
    conv4(16'h0001, 14'h0001);

    repeat (3) @(negedge clk);
    check("q3_drained", q3.size(), 32'd0);
    check("q4_drained", q4.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
